// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream beat bundle shared by the slave (write) and master (read) sides of axis_pkt_fifo.
interface axis_pkt_fifo_if #(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned TUSER_WIDTH = 1
) ();
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic                     tlast;
    logic [TUSER_WIDTH-1:0]   tuser;
    logic                     tvalid;
    logic                     tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// Single-clock AXI-Stream FIFO on inferred RAM with store-and-forward packet mode and force-commit.
// Define AXIS_PKT_FIFO_DROP_EN to drop error/oversized packets instead of force-committing them.
module axis_pkt_fifo #(
    parameter int unsigned TDATA_WIDTH      = 32,
    parameter int unsigned TUSER_WIDTH      = 1,
    parameter int unsigned FIFO_DEPTH       = 512,
    parameter int unsigned PACKET_FIFO      = 1,
    parameter int unsigned PROG_FULL_THRESH = 500
) (
    input  logic                        aclk,
    input  logic                        areset,
    axis_pkt_fifo_if.slave              s_axis,
    axis_pkt_fifo_if.master             m_axis,
    output logic [$clog2(FIFO_DEPTH):0] wr_data_count,
    output logic [$clog2(FIFO_DEPTH):0] pkt_count,
    output logic                        prog_full,
    output logic                        drop_pulse
);
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned KW       = TDATA_WIDTH / 8;
    localparam int unsigned BW       = TDATA_WIDTH + KW + 1 + TUSER_WIDTH;
    localparam int unsigned LAST_BIT = TUSER_WIDTH;
    localparam logic [AW:0] DEPTH_V  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] THRESH_V = (AW+1)'(PROG_FULL_THRESH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);
`ifdef AXIS_PKT_FIFO_DROP_EN
    localparam bit DROP_EN = (PACKET_FIFO != 0);
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_NORMAL, ST_FORCE, ST_DISCARD} state_t;

    state_t        state, state_nx;
    logic [AW:0]   wr_ptr, wr_ptr_nx, commit_ptr, commit_nx;
    logic [AW:0]   rd_ptr, rd_ptr_nx, fetch_ptr, cnt, cnt_nx;
    logic          tready_q, tready_nx, drop_nx, pkt_inc, pkt_dec;
    logic          wr_en, rd_xfer, fetch, out_load, ram_valid, out_valid, full_single;
    logic [BW-1:0] mem [FIFO_DEPTH];
    logic [BW-1:0] wr_beat, ram_q, out_q;

    assign wr_en       = s_axis.tvalid && tready_q;
    assign rd_xfer     = out_valid && m_axis.tready;
    assign rd_ptr_nx   = rd_ptr + (AW+1)'(rd_xfer);
    assign cnt         = wr_ptr - rd_ptr;
    // FIFO holds nothing but one unfinished packet: it can never complete by waiting
    assign full_single = (cnt == DEPTH_V) && (commit_ptr == rd_ptr);
    assign out_load    = ram_valid && (!out_valid || m_axis.tready);
    assign fetch       = (fetch_ptr != commit_ptr) && (!ram_valid || out_load);
    assign pkt_dec     = rd_xfer && out_q[LAST_BIT];
    assign wr_beat     = {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tuser};

    assign s_axis.tready = tready_q;
    assign m_axis.tvalid = out_valid;
    assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser} = out_q;

    // Write-side FSM: commit, force-commit and drop decisions
    always_comb begin
        state_nx  = state;
        wr_ptr_nx = wr_ptr;
        commit_nx = commit_ptr;
        drop_nx   = 1'b0;
        pkt_inc   = 1'b0;
        case (state)
            ST_NORMAL: begin
                if (PACKET_FIFO == 0) begin
                    if (wr_en) begin
                        wr_ptr_nx = wr_ptr + ONE;
                        commit_nx = wr_ptr + ONE;
                        pkt_inc   = s_axis.tlast;
                    end
                end else if (full_single) begin
                    if (DROP_EN) begin
                        wr_ptr_nx = commit_ptr;
                        drop_nx   = 1'b1;
                        state_nx  = ST_DISCARD;
                    end else begin
                        commit_nx = wr_ptr;
                        state_nx  = ST_FORCE;
                    end
                end else if (wr_en) begin
                    if (DROP_EN && s_axis.tlast && s_axis.tuser[0]) begin
                        wr_ptr_nx = commit_ptr;
                        drop_nx   = 1'b1;
                    end else begin
                        wr_ptr_nx = wr_ptr + ONE;
                        if (s_axis.tlast) begin
                            commit_nx = wr_ptr + ONE;
                            pkt_inc   = 1'b1;
                        end
                    end
                end
            end
            ST_FORCE: begin
                if (wr_en) begin
                    wr_ptr_nx = wr_ptr + ONE;
                    commit_nx = wr_ptr + ONE;
                    if (s_axis.tlast) begin
                        pkt_inc  = 1'b1;
                        state_nx = ST_NORMAL;
                    end
                end
            end
            ST_DISCARD: begin
                if (wr_en && s_axis.tlast) state_nx = ST_NORMAL;
            end
            default: state_nx = ST_NORMAL;
        endcase
        cnt_nx    = wr_ptr_nx - rd_ptr_nx;
        tready_nx = (state_nx == ST_DISCARD) || (cnt_nx != DEPTH_V);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= ST_NORMAL;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            rd_ptr        <= '0;
            tready_q      <= 1'b0;
            drop_pulse    <= 1'b0;
            wr_data_count <= '0;
            prog_full     <= 1'b0;
            pkt_count     <= '0;
        end else begin
            state         <= state_nx;
            wr_ptr        <= wr_ptr_nx;
            commit_ptr    <= commit_nx;
            rd_ptr        <= rd_ptr_nx;
            tready_q      <= tready_nx;
            drop_pulse    <= drop_nx;
            wr_data_count <= cnt;
            prog_full     <= (cnt >= THRESH_V);
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_count <= pkt_count + ONE;
                2'b01:   pkt_count <= pkt_count - ONE;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    // Storage array and synchronous read port
    always_ff @(posedge aclk) begin
        if (wr_en && state != ST_DISCARD) mem[wr_ptr[AW-1:0]] <= wr_beat;
        if (fetch) ram_q <= mem[fetch_ptr[AW-1:0]];
    end

    // RAM output stage feeds the FWFT output register; both stages count as stored words
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            fetch_ptr <= '0;
            ram_valid <= 1'b0;
            out_valid <= 1'b0;
            out_q     <= '0;
        end else begin
            if (fetch) fetch_ptr <= fetch_ptr + ONE;
            if (fetch)         ram_valid <= 1'b1;
            else if (out_load) ram_valid <= 1'b0;
            if (out_load) begin
                out_valid <= 1'b1;
                out_q     <= ram_q;
            end else if (m_axis.tready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
- Single-clock AXI-Stream FIFO built from inferred RAM. Successor to the XPM-based AXIS FIFO wrapper.
- Adds true store-and-forward packet mode, committed-packet counting, a force-commit rule for oversized packets, and optional error-packet drop.
- Sits between USB3.0 packet producers and consumers in the same clock domain, where the XPM macro's packet mode and reset polarity do not fit.

Parameters:
- TDATA_WIDTH, 32: data width in bits; multiple of 8, range 8-1024.
- TUSER_WIDTH, 1: sideband width, range 1-64. Bit 0 is the error flag when drop is enabled.
- FIFO_DEPTH, 512: number of entries; power of 2, range 16-65536. AW = log2(FIFO_DEPTH).
- PACKET_FIFO, 1: 1 = store-and-forward; 0 = cut-through.
- PROG_FULL_THRESH, 500: prog_full asserts when word count is at or above this value. Range 1 to FIFO_DEPTH-1.

Ports:
- aclk  in  1  the single clock; all logic on its rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  TDATA_WIDTH  write data.
- s_axis_tkeep  in  TDATA_WIDTH/8  byte qualifiers.
- s_axis_tlast  in  1  end of packet.
- s_axis_tuser  in  TUSER_WIDTH  sideband.
- s_axis_tvalid  in  1  write valid.
- s_axis_tready  out  1  write ready.
- m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser  out  same widths as slave side  read beat.
- m_axis_tvalid  out  1  read valid.
- m_axis_tready  in  1  read ready.
- wr_data_count  out  AW+1  words stored, including uncommitted words.
- pkt_count  out  AW+1  complete committed packets not yet fully read.
- prog_full  out  1  word count >= PROG_FULL_THRESH.
- drop_pulse  out  1  one-cycle strobe per dropped packet.

Behaviour:
- Clock and reset (already decided): one clock, aclk; reset areset is asynchronous and active-high.
- Reset: on assertion, clear wr_ptr, commit_ptr, rd_ptr, counts and the output stage immediately.
  - All outputs read 0, including s_axis_tready, m_axis_tvalid and drop_pulse.
  - s_axis_tready rises at the first aclk edge after areset deasserts.
  - Reset mid-packet discards all content, partial packets included.
- Pointers are AW+1 bits wide and wrap naturally. Word count = wr_ptr - rd_ptr, range 0..FIFO_DEPTH.
- Full: s_axis_tready = 0 when count == FIFO_DEPTH, except while discarding (see Optional Feature).
- Write: a beat is stored when s_axis_tvalid && s_axis_tready; wr_ptr increments.
  - PACKET_FIFO=1: commit_ptr <= wr_ptr+1 on a tlast beat.
  - PACKET_FIFO=0: commit_ptr tracks wr_ptr every cycle.
- Readable region is rd_ptr up to commit_ptr. RAM read is synchronous, feeding a 1-entry output register (FWFT).
- Latency:
  - A beat that makes data readable at edge N gives m_axis_tvalid=1 after edge N+2.
  - In packet mode, the first beat of a packet appears 2 cycles after its tlast beat is accepted.
- Read: m_axis_tvalid holds and the payload stays stable until m_axis_tready. Back-to-back beats stream at 1 per cycle with no bubbles.
- pkt_count:
  - increments on a committed tlast write;
  - decrements when a tlast beat transfers on the master side;
  - does both in the same cycle, leaving it unchanged.
  - In cut-through mode it counts tlast beats written.
- Force-commit: in packet mode, if count == FIFO_DEPTH and commit_ptr == rd_ptr (FIFO full of a single uncommitted packet), commit_ptr <= wr_ptr. The remainder of that packet then passes cut-through until tlast. This prevents deadlock.
- Simultaneous write and read at full: the write is refused (tready=0); the read proceeds. Empty with a simultaneous write: normal latency applies, no bypass.
- prog_full and wr_data_count are registered and update 1 cycle after the pointer change.

Optional Feature:
- Macro: AXIS_PKT_FIFO_DROP_EN. Effective only when PACKET_FIFO=1.
- Defined:
  - A tlast beat with s_axis_tuser[0]=1 rewinds wr_ptr to commit_ptr instead of committing, and pulses drop_pulse for 1 cycle.
  - When the FIFO fills with an uncommitted packet, that packet is rewound and drop_pulse fires.
  - The remaining beats are then accepted (s_axis_tready=1) and discarded through tlast. Force-commit is disabled.
- Undefined: the error bit is stored as ordinary tuser; force-commit applies; drop_pulse is tied to 0.

Test Plan:
- Reset release, PACKET_FIFO=1: write a 4-beat packet, data 1..4 -> m_axis_tvalid stays 0 until tlast is accepted at cycle N, is 1 after N+2; 1,2,3,4 read back with tlast on the 4th; pkt_count goes 1 -> 0.
- DEPTH=16, PACKET_FIFO=0: write 16 beats with m_axis_tready=0 -> s_axis_tready=0 after the 16th; wr_data_count=16; prog_full set at THRESH=12; first read re-enables tready.
- 20-beat packet into DEPTH=16, macro undefined -> force-commit at 16 words; all 20 beats emerge in order; no deadlock.
- Same 20-beat packet with AXIS_PKT_FIFO_DROP_EN -> 1 drop_pulse; no beats output; a following 3-beat good packet reads correctly.
- With macro defined: a packet with tuser[0]=1 on tlast -> dropped, wr_data_count returns to its prior value; the next packet is unaffected.
- Assert areset mid-read of a 5-beat packet -> all outputs 0 asynchronously; after release wr_data_count=0 and pkt_count=0.
